// File: rtl/buffer_fifo_if.sv
// buffer_fifo_if: receive/transmit valid-ready handshake bundle.
// master drives words in and takes words out; slave is the FIFO.
interface buffer_fifo_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] receive;
    logic             receive_valid;
    logic             receive_ready;
    logic [WIDTH-1:0] transmit;
    logic             transmit_valid;
    logic             transmit_ready;

    modport master (
        output receive,
        output receive_valid,
        output transmit_ready,
        input  receive_ready,
        input  transmit,
        input  transmit_valid
    );

    modport slave (
        input  receive,
        input  receive_valid,
        input  transmit_ready,
        output receive_ready,
        output transmit,
        output transmit_valid
    );
endinterface

// File: rtl/buffer_fifo.sv
// buffer_fifo: DEPTH x WIDTH in-order queue with occupancy,
// synchronous flush and sticky overflow; no receive->transmit path.
module buffer_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    buffer_fifo_if.slave  bus,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign bus.receive_ready  = !full;
    assign bus.transmit_valid = !empty;
    assign bus.transmit       = mem[rd_ptr];

    assign push = bus.receive_valid & !full;
    assign pop  = !empty & bus.transmit_ready;

    // Storage: cleared on reset, written on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= bus.receive;
        end
    end

    // Pointers, occupancy and overflow; flush overrides handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.receive_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
